// File: rtl/dbg_bridge_if.sv
// dbg_bridge_if: host byte link and core debug port seen by dbg_bridge.
// The bridge connects through the master modport; the host link and the
// core wrapper (or a testbench) drive the slave side.
interface dbg_bridge_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;

    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o,
               dbg_data_o, busy_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, dbg_data_i, dbg_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, dbg_cmd_o, dbg_addr_o,
               dbg_data_o, busy_o
    );
endinterface

// File: rtl/dbg_bridge.sv
// dbg_bridge: turns a 9-byte host frame (CMD, ADDR LSB-first, DATA LSB-first)
// into one debug command on the core port, runs the 4-phase ready handshake
// and returns a 5-byte response (STATUS, RDATA LSB-first).
// Optional build macro DBG_BRIDGE_TIMEOUT_EN adds a WAIT_RDY watchdog of
// TIMEOUT_CYCLES cycles that aborts with STATUS 0xEE.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_CMD   | idle; zero bytes discarded, nonzero byte latched as command
// RX_ADDR  | collecting 4 address bytes
// RX_DATA  | collecting 4 write-data bytes
// ISSUE    | load dbg_cmd/addr/data outputs (one cycle)
// WAIT_RDY | command held until the core raises dbg_ready_i
// RELEASE  | command dropped, waiting for dbg_ready_i to fall
// TX       | sending STATUS and RDATA bytes
module dbg_bridge #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dbg_bridge_if.master bus
);
    typedef enum logic [2:0] {
        RX_CMD, RX_ADDR, RX_DATA, ISSUE, WAIT_RDY, RELEASE, TX
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, status_q, dbg_cmd_q;
    logic [31:0] addr_q, data_q, rdata_q, dbg_addr_q, dbg_data_q;
    logic [2:0]  cnt_q;
    logic        rx_rdy, tx_vld, busy, rx_fire, tx_fire, tmo_hit;
    logic [7:0]  tx_byte;

    assign rx_fire = rx_rdy && bus.rx_valid_i;
    assign tx_fire = tx_vld && bus.tx_ready_i;

`ifdef DBG_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Watchdog: zero outside WAIT_RDY, counts each cycle spent inside it.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != WAIT_RDY) tmo_q <= '0;
        else                              tmo_q <= tmo_q + TMO_W'(1);
    end

    // The last waiting cycle is the one where the count is TIMEOUT_CYCLES-1.
    assign tmo_hit = (state_q == WAIT_RDY) && !bus.dbg_ready_i &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RX_CMD;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        rx_rdy  = 1'b0;
        tx_vld  = 1'b0;
        busy    = (state_q != RX_CMD);
        tx_byte = 8'h00;
        case (state_q)
            RX_CMD: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i && bus.rx_data_i != 8'h00) state_d = RX_ADDR;
            end
            RX_ADDR: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i && cnt_q == 3'd3) state_d = RX_DATA;
            end
            RX_DATA: begin
                rx_rdy = 1'b1;
                if (bus.rx_valid_i && cnt_q == 3'd3) state_d = ISSUE;
            end
            ISSUE:    state_d = WAIT_RDY;
            WAIT_RDY: begin
                // A ready on the timeout cycle still counts as success.
                if (bus.dbg_ready_i) state_d = RELEASE;
                else if (tmo_hit)    state_d = TX;
            end
            RELEASE: if (!bus.dbg_ready_i) state_d = TX;
            TX: begin
                tx_vld = 1'b1;
                case (cnt_q)
                    3'd0:    tx_byte = status_q;
                    3'd1:    tx_byte = rdata_q[7:0];
                    3'd2:    tx_byte = rdata_q[15:8];
                    3'd3:    tx_byte = rdata_q[23:16];
                    3'd4:    tx_byte = rdata_q[31:24];
                    default: tx_byte = 8'h00;
                endcase
                if (bus.tx_ready_i && cnt_q == 3'd4) state_d = RX_CMD;
            end
            default: state_d = RX_CMD;
        endcase
    end

    // Frame assembly, command outputs and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            cnt_q      <= '0;
            dbg_cmd_q  <= '0;
            dbg_addr_q <= '0;
            dbg_data_q <= '0;
        end else begin
            case (state_q)
                RX_CMD: if (rx_fire && bus.rx_data_i != 8'h00) begin
                    cmd_q <= bus.rx_data_i;
                    cnt_q <= '0;
                end
                RX_ADDR: if (rx_fire) begin
                    addr_q <= {bus.rx_data_i, addr_q[31:8]};
                    cnt_q  <= (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
                end
                RX_DATA: if (rx_fire) begin
                    data_q <= {bus.rx_data_i, data_q[31:8]};
                    cnt_q  <= (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
                end
                ISSUE: begin
                    dbg_cmd_q  <= cmd_q;
                    dbg_addr_q <= addr_q;
                    dbg_data_q <= data_q;
                end
                WAIT_RDY: begin
                    if (bus.dbg_ready_i) begin
                        rdata_q   <= bus.dbg_data_i;
                        status_q  <= 8'h00;
                        dbg_cmd_q <= 8'h00;
                        cnt_q     <= '0;
                    end else if (tmo_hit) begin
                        rdata_q   <= '0;
                        status_q  <= 8'hEE;
                        dbg_cmd_q <= 8'h00;
                        cnt_q     <= '0;
                    end
                end
                TX: if (tx_fire) cnt_q <= (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready_o = rx_rdy;
    assign bus.tx_valid_o = tx_vld;
    assign bus.tx_data_o  = tx_byte;
    assign bus.busy_o     = busy;
    assign bus.dbg_cmd_o  = dbg_cmd_q;
    assign bus.dbg_addr_o = dbg_addr_q;
    assign bus.dbg_data_o = dbg_data_q;
endmodule

// File: tb/tb_dbg_bridge.sv
// tb_dbg_bridge: drives host frames and a simple core model into dbg_bridge
// and compares the command port and response bytes with frame-level
// expectations computed here.
module tb_dbg_bridge;
    localparam int TMO = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    dbg_bridge_if bus_if();

    dbg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if.master)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int issues = 0;
    int exp_issues = 0;
    logic [7:0] prev_cmd = 8'h00;

    // Count rising edges of a nonzero command on the core port.
    always @(posedge clk_i) begin
        if (rst_i) prev_cmd = 8'h00;
        else begin
            if (bus_if.dbg_cmd_o != 8'h00 && prev_cmd == 8'h00) issues++;
            prev_cmd = bus_if.dbg_cmd_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.rx_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus_if.rx_data_i = 8'($urandom);
            step();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        bus_if.rx_data_i  = b;
        bus_if.rx_valid_i = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus_if.rx_ready_o) done = 1'b1;
            step();
        end
        bus_if.rx_valid_i = 1'b0;
        if (!done) check("rx_accept_bound", 0, 1);
    endtask

    // mode 0: normal handshake, 1: reset while waiting, 2: core never ready
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata,
                             input int mode, input bit bp, input int nfill,
                             input int rdy_dly);
        logic [7:0]  frame [9];
        logic [7:0]  exp_tx [5];
        logic [31:0] exp_rdata;
        logic [7:0]  exp_status;
        logic [7:0]  prev_tx;
        bit          have_prev;
        int          got;
        int          stall;

        frame[0] = cmd;
        for (int i = 0; i < 4; i++) begin
            frame[1 + i] = addr[8*i +: 8];
            frame[5 + i] = data[8*i +: 8];
        end
        exp_issues++;

        for (int i = 0; i < nfill; i++) begin
            idle($urandom_range(0, 1));
            send_byte(8'h00);
        end
        if (nfill > 0) check("fill_idle", 32'(bus_if.busy_o), 0);
        for (int k = 0; k < 9; k++) begin
            idle($urandom_range(0, 2));
            send_byte(frame[k]);
        end

        // One cycle after the last byte: ISSUE, command not yet visible.
        check("cmd_early", 32'(bus_if.dbg_cmd_o), 0);
        check("rx_ready_issue", 32'(bus_if.rx_ready_o), 0);
        step();
        check("cmd_issue", 32'(bus_if.dbg_cmd_o), 32'(cmd));
        check("addr_issue", bus_if.dbg_addr_o, addr);
        check("data_issue", bus_if.dbg_data_o, data);

        if (mode == 1) begin
            for (int i = 0; i < rdy_dly; i++) step();
            rst_i = 1'b1;
            step();
            check("rst_cmd", 32'(bus_if.dbg_cmd_o), 0);
            check("rst_busy", 32'(bus_if.busy_o), 0);
            check("rst_rx_ready", 32'(bus_if.rx_ready_o), 1);
            check("rst_tx_valid", 32'(bus_if.tx_valid_o), 0);
            check("rst_addr", bus_if.dbg_addr_o, 0);
            rst_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                check("rst_no_tx", 32'(bus_if.tx_valid_o), 0);
            end
            check("issue_count", issues, exp_issues);
            return;
        end

        if (mode == 2) begin
            exp_status = 8'hEE;
            exp_rdata  = 32'h0;
            for (int i = 1; i < TMO; i++) step();
            check("tmo_cmd_hold", 32'(bus_if.dbg_cmd_o), 32'(cmd));
            step();
            check("tmo_cmd_clear", 32'(bus_if.dbg_cmd_o), 0);
        end else begin
            exp_status = 8'h00;
            exp_rdata  = rdata;
            for (int i = 0; i < rdy_dly; i++) begin
                check("cmd_hold", 32'(bus_if.dbg_cmd_o), 32'(cmd));
                step();
            end
            bus_if.dbg_ready_i = 1'b1;
            bus_if.dbg_data_i  = rdata;
            step();
            check("cmd_clear", 32'(bus_if.dbg_cmd_o), 0);
            bus_if.dbg_data_i = $urandom;
            for (int i = 0; i < 1 + int'($urandom_range(0, 3)); i++) begin
                check("tx_before_release", 32'(bus_if.tx_valid_o), 0);
                step();
            end
            bus_if.dbg_ready_i = 1'b0;
            step();
        end

        exp_tx[0] = exp_status;
        for (int i = 0; i < 4; i++) exp_tx[1 + i] = exp_rdata[8*i +: 8];

        got       = 0;
        have_prev = 1'b0;
        stall     = bp ? 10 : 0;
        if (bp) begin
            bus_if.rx_valid_i = 1'b1;
            bus_if.rx_data_i  = 8'h00;
        end
        for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
            if (bp && got == 2 && stall > 0) begin
                bus_if.tx_ready_i = 1'b0;
                stall--;
            end else begin
                bus_if.tx_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (bp) check("bp_rx_ready", 32'(bus_if.rx_ready_o), 0);
            check("tx_valid", 32'(bus_if.tx_valid_o), 1);
            if (have_prev) check("tx_stable", 32'(bus_if.tx_data_o), 32'(prev_tx));
            if (bus_if.tx_ready_i) begin
                check($sformatf("tx_byte%0d", got), 32'(bus_if.tx_data_o), 32'(exp_tx[got]));
                got++;
                have_prev = 1'b0;
            end else begin
                prev_tx   = bus_if.tx_data_o;
                have_prev = 1'b1;
            end
            step();
        end
        bus_if.tx_ready_i = 1'b0;
        bus_if.rx_valid_i = 1'b0;
        check("tx_count", got, 5);
        check("done_tx_valid", 32'(bus_if.tx_valid_o), 0);
        check("done_busy", 32'(bus_if.busy_o), 0);
        check("done_rx_ready", 32'(bus_if.rx_ready_o), 1);
        check("addr_hold", bus_if.dbg_addr_o, addr);
        check("data_hold", bus_if.dbg_data_o, data);
        check("issue_count", issues, exp_issues);
    endtask

    initial begin
        bus_if.rx_data_i   = 8'h00;
        bus_if.rx_valid_i  = 1'b0;
        bus_if.tx_ready_i  = 1'b0;
        bus_if.dbg_data_i  = 32'h0;
        bus_if.dbg_ready_i = 1'b0;
        rst_i = 1'b1;
        step();
        step();
        check("reset_cmd", 32'(bus_if.dbg_cmd_o), 0);
        check("reset_addr", bus_if.dbg_addr_o, 0);
        check("reset_data", bus_if.dbg_data_o, 0);
        check("reset_tx_valid", 32'(bus_if.tx_valid_o), 0);
        check("reset_tx_data", 32'(bus_if.tx_data_o), 0);
        check("reset_busy", 32'(bus_if.busy_o), 0);
        check("reset_rx_ready", 32'(bus_if.rx_ready_o), 1);
        rst_i = 1'b0;
        step();

        run_frame(8'h01, 32'h12345678, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 3);
        run_frame(8'h02, 32'h00001000, 32'h0, 32'hCAFEBABE, 0, 1'b0, 0, 2);
        run_frame(8'h02, 32'h00002000, 32'h0, 32'h01234567, 0, 1'b1, 0, 1);
        run_frame(8'h03, 32'hA5A5_0004, 32'h5A5A_1234, 32'h89ABCDEF, 0, 1'b0, 2, 0);
        for (int n = 0; n < 16; n++) begin
            run_frame(8'($urandom_range(1, 255)), $urandom, $urandom, $urandom, 0,
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                      $urandom_range(0, 5));
        end
        run_frame(8'h04, 32'h0000_0040, 32'h1111_2222, 32'h0, 1, 1'b0, 0, 2);
`ifdef DBG_BRIDGE_TIMEOUT_EN
        run_frame(8'h05, 32'h0000_0080, 32'h3333_4444, 32'h0, 2, 1'b0, 0, 0);
`endif
        run_frame(8'h06, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
